// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the branch target buffer.
// The pipeline drives fetch and resolution; the predictor answers with the next-PC guess.
interface branch_predictor_if;
  logic [31:0] fetch_pc;
  logic [31:0] predicted_pc;
  logic        pred_taken;
  logic        pred_valid;
  logic        update_btb;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;

  modport master (
    output fetch_pc, update_btb, update_pc, update_target, update_taken,
    input  predicted_pc, pred_taken, pred_valid
  );

  modport slave (
    input  fetch_pc, update_btb, update_pc, update_target, update_taken,
    output predicted_pc, pred_taken, pred_valid
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from table state; training writes one entry per clock.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic               valid_r  [ENTRIES];
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [31:0]        target_r [ENTRIES];
  logic [1:0]         ctr_r    [ENTRIES];

  logic [IDX_W-1:0]   f_idx_s;
  logic [TAG_W-1:0]   f_tag_s;
  logic               f_hit_s;
  logic               f_taken_s;

  logic [IDX_W-1:0]   u_idx_s;
  logic [TAG_W-1:0]   u_tag_s;
  logic               u_hit_s;
  logic               wr_en_s;
  logic               nxt_valid_s;
  logic [TAG_W-1:0]   nxt_tag_s;
  logic [31:0]        nxt_target_s;
  logic [1:0]         nxt_ctr_s;
  logic               unused_pc_bits_s;

  assign f_idx_s = bp.fetch_pc[IDX_W+1:2];
  assign f_tag_s = bp.fetch_pc[31:IDX_W+2];
  assign u_idx_s = bp.update_pc[IDX_W+1:2];
  assign u_tag_s = bp.update_pc[31:IDX_W+2];
  assign unused_pc_bits_s = ^bp.update_pc[1:0];

  // Lookup: hit detection and next-PC selection for the fetch stage.
  always_comb begin
    f_hit_s   = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
    f_taken_s = f_hit_s && ctr_r[f_idx_s][1];
    if (f_taken_s) begin
      bp.predicted_pc = target_r[f_idx_s];
    end else begin
      bp.predicted_pc = bp.fetch_pc + 32'd4;
    end
    bp.pred_valid = f_hit_s;
    bp.pred_taken = f_taken_s;
  end

  // Training: compute the new contents of the entry addressed by update_pc.
  always_comb begin
    u_hit_s      = valid_r[u_idx_s] && (tag_r[u_idx_s] == u_tag_s);
    wr_en_s      = 1'b0;
    nxt_valid_s  = valid_r[u_idx_s];
    nxt_tag_s    = tag_r[u_idx_s];
    nxt_target_s = target_r[u_idx_s];
    nxt_ctr_s    = ctr_r[u_idx_s];
    if (bp.update_btb) begin
      if (u_hit_s) begin
        wr_en_s = 1'b1;
        if (bp.update_taken) begin
          nxt_target_s = bp.update_target;
          if (ctr_r[u_idx_s] != 2'b11) begin
            nxt_ctr_s = ctr_r[u_idx_s] + 2'b01;
          end else begin
            nxt_ctr_s = 2'b11;
          end
        end else begin
          if (ctr_r[u_idx_s] != 2'b00) begin
            nxt_ctr_s = ctr_r[u_idx_s] - 2'b01;
          end else begin
            nxt_ctr_s = 2'b00;
          end
        end
      end else if (bp.update_taken) begin
        // Taken miss allocates (or evicts an alias) as weakly taken.
        wr_en_s      = 1'b1;
        nxt_valid_s  = 1'b1;
        nxt_tag_s    = u_tag_s;
        nxt_target_s = bp.update_target;
        nxt_ctr_s    = 2'b10;
      end else begin
        wr_en_s = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Table storage: async clear, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'd0;
        ctr_r[i]    <= 2'b01;
      end
    end else if (wr_en_s) begin
      valid_r[u_idx_s]  <= nxt_valid_s;
      tag_r[u_idx_s]    <= nxt_tag_s;
      target_r[u_idx_s] <= nxt_target_s;
      ctr_r[u_idx_s]    <= nxt_ctr_s;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a word-address reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_branch_predictor;
  localparam int ENTRIES = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  branch_predictor_if bp_if ();

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each slot remembers the full word address it was trained on.
  bit          m_valid [ENTRIES];
  logic [29:0] m_word  [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];

  function automatic int slot(input logic [31:0] pc);
    return int'(pc[31:2]) & (ENTRIES - 1);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_word[slot(pc)] == pc[31:2]);
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] <= 1'b0;
        m_word[i]  <= 30'd0;
        m_tgt[i]   <= 32'd0;
        m_ctr[i]   <= 1;
      end
    end else if (bp_if.update_btb) begin
      if (m_hit(bp_if.update_pc)) begin
        if (bp_if.update_taken) begin
          m_ctr[slot(bp_if.update_pc)] <= (m_ctr[slot(bp_if.update_pc)] < 3) ? m_ctr[slot(bp_if.update_pc)] + 1 : 3;
          m_tgt[slot(bp_if.update_pc)] <= bp_if.update_target;
        end else begin
          m_ctr[slot(bp_if.update_pc)] <= (m_ctr[slot(bp_if.update_pc)] > 0) ? m_ctr[slot(bp_if.update_pc)] - 1 : 0;
        end
      end else if (bp_if.update_taken) begin
        m_valid[slot(bp_if.update_pc)] <= 1'b1;
        m_word[slot(bp_if.update_pc)]  <= bp_if.update_pc[31:2];
        m_tgt[slot(bp_if.update_pc)]   <= bp_if.update_target;
        m_ctr[slot(bp_if.update_pc)]   <= 2;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_pred(input string name, input bit pv, input bit pt, input logic [31:0] npc);
    check({name, ".pred_valid"}, {31'd0, bp_if.pred_valid}, {31'd0, pv});
    check({name, ".pred_taken"}, {31'd0, bp_if.pred_taken}, {31'd0, pt});
    check({name, ".predicted_pc"}, bp_if.predicted_pc, npc);
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    check("model.pred_valid", {31'd0, bp_if.pred_valid}, {31'd0, m_hit(bp_if.fetch_pc)});
    check("model.pred_taken", {31'd0, bp_if.pred_taken}, {31'd0, m_taken(bp_if.fetch_pc)});
    check("model.predicted_pc", bp_if.predicted_pc, m_next(bp_if.fetch_pc));
  end

  task automatic cyc(input logic [31:0] fpc, input bit upd, input logic [31:0] upc,
                     input logic [31:0] utgt, input bit utk);
    @(posedge clk);
    #1;
    bp_if.fetch_pc      = fpc;
    bp_if.update_btb    = upd;
    bp_if.update_pc     = upc;
    bp_if.update_target = utgt;
    bp_if.update_taken  = utk;
    @(negedge clk);
  endtask

  task automatic look(input logic [31:0] fpc);
    cyc(fpc, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bp_if.fetch_pc      = 32'h100;
    bp_if.update_btb    = 1'b0;
    bp_if.update_pc     = 32'd0;
    bp_if.update_target = 32'd0;
    bp_if.update_taken  = 1'b0;
    repeat (2) @(negedge clk);
    expect_pred("reset", 1'b0, 1'b0, 32'h104);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Allocation: same-cycle lookup sees the old table, next cycle the new entry.
    cyc(32'h100, 1'b1, 32'h100, 32'h200, 1'b1);
    expect_pred("same_cycle", 1'b0, 1'b0, 32'h104);
    look(32'h100);
    expect_pred("alloc", 1'b1, 1'b1, 32'h200);

    // Hysteresis and saturation.
    cyc(32'h100, 1'b1, 32'h100, 32'h200, 1'b0);
    look(32'h100);
    expect_pred("ctr01", 1'b1, 1'b0, 32'h104);
    cyc(32'h100, 1'b1, 32'h100, 32'h200, 1'b1);
    look(32'h100);
    expect_pred("ctr10", 1'b1, 1'b1, 32'h200);
    repeat (3) cyc(32'h100, 1'b1, 32'h100, 32'h200, 1'b1);
    look(32'h100);
    expect_pred("ctr11", 1'b1, 1'b1, 32'h200);
    cyc(32'h100, 1'b1, 32'h100, 32'h200, 1'b0);
    look(32'h100);
    expect_pred("sat_one_nt", 1'b1, 1'b1, 32'h200);
    cyc(32'h100, 1'b1, 32'h100, 32'h200, 1'b0);
    look(32'h100);
    expect_pred("sat_two_nt", 1'b1, 1'b0, 32'h104);
    repeat (3) cyc(32'h100, 1'b1, 32'h100, 32'h200, 1'b0);
    cyc(32'h100, 1'b1, 32'h100, 32'h200, 1'b1);
    look(32'h100);
    expect_pred("floor00", 1'b1, 1'b0, 32'h104);

    // Aliasing on index 0.
    cyc(32'h100, 1'b1, 32'h140, 32'h300, 1'b1);
    look(32'h100);
    expect_pred("alias_evicted", 1'b0, 1'b0, 32'h104);
    look(32'h140);
    expect_pred("alias_new", 1'b1, 1'b1, 32'h300);
    cyc(32'h140, 1'b1, 32'h100, 32'h500, 1'b0);
    look(32'h140);
    expect_pred("nt_miss_keeps", 1'b1, 1'b1, 32'h300);
    look(32'h100);
    expect_pred("nt_miss_no_alloc", 1'b0, 1'b0, 32'h104);

    // Asynchronous reset mid-training, held across an edge with an update pending.
    cyc(32'h140, 1'b1, 32'h104, 32'h400, 1'b1);
    look(32'h104);
    expect_pred("pre_reset", 1'b1, 1'b1, 32'h400);
    #1;
    bp_if.fetch_pc      = 32'h140;
    bp_if.update_btb    = 1'b1;
    bp_if.update_pc     = 32'h140;
    bp_if.update_target = 32'h999;
    bp_if.update_taken  = 1'b1;
    rst_n = 1'b0;
    #1;
    expect_pred("async_reset", 1'b0, 1'b0, 32'h144);
    @(negedge clk);
    expect_pred("reset_hold", 1'b0, 1'b0, 32'h144);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bp_if.update_btb = 1'b0;
    look(32'h104);
    expect_pred("post_reset_104", 1'b0, 1'b0, 32'h108);
    look(32'h140);
    expect_pred("post_reset_140", 1'b0, 1'b0, 32'h144);

    // Wrap-around at the top of the address space.
    look(32'hFFFF_FFFC);
    expect_pred("wrap", 1'b0, 1'b0, 32'h0000_0000);
    cyc(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h8, 1'b1);
    look(32'hFFFF_FFFC);
    expect_pred("wrap_trained", 1'b1, 1'b1, 32'h8);

    // Spread of entries across all indices; the model checks every cycle.
    for (int i = 0; i < ENTRIES; i++) begin
      cyc(32'h3000 + 32'(i * 4), 1'b1, 32'h3000 + 32'(i * 4), 32'h8000 + 32'(i * 16), 1'b1);
    end
    for (int i = 0; i < ENTRIES; i++) begin
      cyc(32'h3000 + 32'(i * 4), 1'b1, 32'h3000 + 32'(i * 4), 32'h0, (i % 2) == 0);
      look(32'h3000 + 32'(i * 4));
      look(32'h7000 + 32'(i * 4));
    end
    look(32'h3004);
    expect_pred("spread_odd", 1'b1, 1'b0, 32'h3008);
    look(32'h3008);
    expect_pred("spread_even", 1'b1, 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
